s3_execute_stage: RTL and testbench
===================================

// Module: s3_execute_stage
// PURPOSE
//  Consumer end of the S1->S2 pipeline register: takes S2_* operands/control, executes the ALU op
//  and registers result + write-back control into S3 outputs that drive the register-file write port.
//  Most ops take a single cycle. ALUOP 3'b111 (MUL) runs an iterative multiply. During it, Stall
//  freezes S1/S2 upstream and bubbles (WriteEnable=0) enter S3.
// PARAMETERS
//  MUL_BITS_PER_CYCLE  1  multiplier bits retired per BUSY cycle; legal 1,2,4,8; N = 32/MUL_BITS_PER_CYCLE
// PORTS
//  clk             in   1   single clock, all state on posedge
//  rst_n           in   1   asynchronous, active-low reset
//  S2_ReadData1    in   32  operand A
//  S2_ReadData2    in   32  operand B when S2_DataSrc=0
//  S2_Imm          in   16  immediate, sign-extended to 32 when S2_DataSrc=1
//  S2_DataSrc      in   1   0: B=ReadData2, 1: B=sext(Imm)
//  S2_ALUOP        in   3   000 ADD,001 SUB,010 AND,011 OR,100 XOR,101 SLL(A<<B[4:0]),110 SLT signed,111 MUL
//  S2_WriteSelect  in   5   destination register
//  S2_WriteEnable  in   1   instruction writes back
//  S3_ALUOut       out  32  registered result
//  S3_WriteSelect  out  5   registered destination
//  S3_WriteEnable  out  1   registered write strobe to register file
//  Stall           out  1   combinational; upstream holds all S2_* stable while high
// BEHAVIOUR
//  - Reset (async, any state): S3_ALUOut=0, S3_WriteSelect=0, S3_WriteEnable=0, FSM=IDLE, Stall=0.
//  - Arithmetic mod 2^32; overflow ignored. SLT yields 32'd1/32'd0. MUL yields low 32 bits of A*B.
//  - Writes to R0 are suppressed: S3_WriteEnable <= S2_WriteEnable && (S2_WriteSelect != 0).
//  - IDLE, op != MUL: 1-cycle latency. Next edge loads S3_* from the ALU result and S2 control.
//  - IDLE, op == MUL: Stall=1 this cycle. At the edge, latch A, B, WriteSelect and WriteEnable.
//    Clear acc and cnt, S3_WriteEnable<=0 (bubble). Go to BUSY.
//  - BUSY: each edge adds MUL_BITS_PER_CYCLE shifted partial products and cnt++.
//    Stall = (cnt != N-1); S3_WriteEnable<=0 on every non-final edge.
//    Final edge (cnt==N-1, Stall=0): S3_* <= product and latched control; upstream advances; go to IDLE.
//  - MUL occupies S2 for N+1 cycles. Stall is high N cycles. Result is visible N+1 edges after issue.
//  - Back-to-back MULs: the second is detected in IDLE the cycle after the first completes; no overlap.
//  - rst_n low mid-MUL: operation aborted, no write-back, Stall drops immediately.
//  - S2_* changes while Stall=1 are a protocol violation. BUSY uses latched copies only.
// CONFIGURATION
//  - S3_MUL_EN defined: iterative multiplier and IDLE/BUSY FSM as above.
//  - S3_MUL_EN undefined: op 111 gives S3_ALUOut=32'd0 in 1 cycle. Stall is tied 0.
//    No FSM or multiplier logic is built.
// STRUCTURE
//  - s3_pkg: ALUOP localparams (ALU_ADD..ALU_MUL), FSM state encoding (ST_IDLE, ST_BUSY), width constants.
//  - Sub-module s3_iter_mul (start, a, b -> busy, last, product).
//    Instantiated only under S3_MUL_EN. The top keeps the combinational ALU, the S3 register and Stall.
// TESTING
//  - Reset: rst_n=0 asynchronously, mid-stream -> all S3 outputs 0 and Stall 0 before the next clk edge.
//  - Imm ADD: A=5, Imm=16'hFFFF, DataSrc=1, ADD, WS=3, WE=1 -> next edge ALUOut=4, WS=3, WE=1.
//  - SLT/SLL: A=32'hFFFFFFFF, B=1, SLT -> ALUOut=1.
//    A=1, B=32'h21, SLL -> ALUOut=2 (shift uses B[4:0]).
//  - R0 guard: WS=0, WE=1, ADD -> S3_WriteEnable=0.
//  - MUL (BPC=1, S3_MUL_EN): A=7, B=6, WS=9, WE=1.
//    -> Stall high 32 cycles, S3_WriteEnable=0 throughout.
//    -> 33rd edge: ALUOut=42, WS=9, WE=1.
//    -> following ADD lands one edge later.
//    A=B=32'h10000 -> 0.
//  - Reset mid-MUL: rst_n low at BUSY cnt=10 -> Stall=0, IDLE, no write-back of the product.
//    Without S3_MUL_EN, op 111 -> ALUOut=0 after 1 edge, Stall never high.

Source files
------------

// File: rtl/s3_pkg.sv
// s3_pkg: definitions shared by the S3 execute stage and its iterative multiplier.
//   - ALU opcode encodings (ALU_ADD .. ALU_MUL)
//   - multiplier FSM state encoding (ST_IDLE, ST_BUSY)
//   - datapath width constants and an immediate sign-extension helper
package s3_pkg;

   localparam int DATA_W = 32;
   localparam int IMM_W  = 16;
   localparam int REG_W  = 5;
   localparam int OP_W   = 3;
   localparam int CNT_W  = 5;   // holds N-1 for every legal bits-per-cycle setting

   localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [OP_W-1:0] ALU_AND = 3'b010;
   localparam logic [OP_W-1:0] ALU_OR  = 3'b011;
   localparam logic [OP_W-1:0] ALU_XOR = 3'b100;
   localparam logic [OP_W-1:0] ALU_SLL = 3'b101;
   localparam logic [OP_W-1:0] ALU_SLT = 3'b110;
   localparam logic [OP_W-1:0] ALU_MUL = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mul_state_e;

   function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
      return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
   endfunction

endpackage

// File: rtl/s3_iter_mul.sv
// s3_iter_mul: iterative shift-add multiplier, low 32 bits of a*b.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : in IDLE, latch a/b and begin (ignored while busy)
//   a, b       : operands, sampled on the start edge only
//   busy       : FSM is in BUSY
//   last       : busy and this edge retires the final bits
//   product    : accumulator including this cycle's partial products;
//                holds the full product while last is high
//   state_o    : FSM state, exposed for observation
// Retires MUL_BITS_PER_CYCLE multiplier bits per BUSY cycle; N = 32/MUL_BITS_PER_CYCLE.
module s3_iter_mul
   import s3_pkg::*;
#(
   parameter int MUL_BITS_PER_CYCLE = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic              busy,
   output logic              last,
   output logic [DATA_W-1:0] product,
   output mul_state_e        state_o
);

   localparam int N = DATA_W / MUL_BITS_PER_CYCLE;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   mul_state_e        state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;     // multiplicand, pre-shifted to the current bit position
   logic [DATA_W-1:0] b_q, b_d;     // multiplier, unretired bits shifted down to bit 0
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_sum;

   always_comb begin
      acc_sum = acc_q;
      for (int i = 0; i < MUL_BITS_PER_CYCLE; i++) begin
         if (b_q[i]) acc_sum = acc_sum + (a_q << i);
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            acc_d = acc_sum;
            a_d   = a_q << MUL_BITS_PER_CYCLE;
            b_d   = b_q >> MUL_BITS_PER_CYCLE;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy    = (state_q == ST_BUSY);
   assign last    = busy && (cnt_q == CNT_LAST);
   assign product = acc_sum;
   assign state_o = state_q;

endmodule

// File: rtl/s3_execute_stage.sv
// s3_execute_stage: execute stage at the consumer end of the S1->S2 pipeline register.
//   clk, rst_n        : clock, asynchronous active-low reset
//   S2_ReadData1      : operand A
//   S2_ReadData2      : operand B when S2_DataSrc=0
//   S2_Imm            : immediate, sign-extended when S2_DataSrc=1
//   S2_ALUOP          : ADD,SUB,AND,OR,XOR,SLL,SLT(signed),MUL
//   S2_WriteSelect/WriteEnable : write-back destination and strobe
//   S3_ALUOut/WriteSelect/WriteEnable : registered result driving the register-file write port
//   Stall             : combinational hold request to S1/S2
// Build option S3_MUL_EN: when defined, MUL runs on the iterative multiplier and
// stalls upstream; when undefined, MUL yields 0 in one cycle and Stall is tied 0.
//
// Stall protocol: while Stall is high, upstream holds every S2_* input stable and
// the current S2 instruction is not consumed. An S2 instruction is consumed on a
// rising edge where Stall is low. A MUL is consumed on its final multiply edge.
module s3_execute_stage
   import s3_pkg::*;
`ifdef S3_MUL_EN
#(
   parameter int MUL_BITS_PER_CYCLE = 1
)
`endif
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] S2_ReadData1,
   input  logic [DATA_W-1:0] S2_ReadData2,
   input  logic [IMM_W-1:0]  S2_Imm,
   input  logic              S2_DataSrc,
   input  logic [OP_W-1:0]   S2_ALUOP,
   input  logic [REG_W-1:0]  S2_WriteSelect,
   input  logic              S2_WriteEnable,
   output logic [DATA_W-1:0] S3_ALUOut,
   output logic [REG_W-1:0]  S3_WriteSelect,
   output logic              S3_WriteEnable,
   output logic              Stall
);

   logic [DATA_W-1:0] op_b;
   logic [DATA_W-1:0] alu_res;
   logic              wb_en;

   logic [DATA_W-1:0] s3_aluout_q, s3_aluout_d;
   logic [REG_W-1:0]  s3_ws_q, s3_ws_d;
   logic              s3_we_q, s3_we_d;

   always_comb begin
      op_b = S2_DataSrc ? sext_imm(S2_Imm) : S2_ReadData2;
      case (S2_ALUOP)
         ALU_ADD: alu_res = S2_ReadData1 + op_b;
         ALU_SUB: alu_res = S2_ReadData1 - op_b;
         ALU_AND: alu_res = S2_ReadData1 & op_b;
         ALU_OR:  alu_res = S2_ReadData1 | op_b;
         ALU_XOR: alu_res = S2_ReadData1 ^ op_b;
         ALU_SLL: alu_res = S2_ReadData1 << op_b[4:0];
         ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, ($signed(S2_ReadData1) < $signed(op_b))};
         default: alu_res = '0;   // MUL without the multiplier
      endcase
      // R0 is hardwired zero, so writes to it never reach the register file.
      wb_en = S2_WriteEnable && (S2_WriteSelect != '0);
   end

`ifdef S3_MUL_EN
   logic              mul_start;
   logic              mul_busy;
   logic              mul_last;
   logic [DATA_W-1:0] mul_product;
   mul_state_e        mul_state;
   logic [REG_W-1:0]  lat_ws_q, lat_ws_d;
   logic              lat_we_q, lat_we_d;

   s3_iter_mul #(
      .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE)
   ) u_iter_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .a       (S2_ReadData1),
      .b       (op_b),
      .busy    (mul_busy),
      .last    (mul_last),
      .product (mul_product),
      .state_o (mul_state)
   );

   // rst_n gates Stall so an aborted MUL releases upstream immediately, even
   // though the held S2 instruction still decodes as MUL.
   assign mul_start = rst_n && (mul_state == ST_IDLE) && (S2_ALUOP == ALU_MUL);
   assign Stall     = rst_n && (mul_start || (mul_busy && !mul_last));

   always_comb begin
      s3_aluout_d = alu_res;
      s3_ws_d     = S2_WriteSelect;
      s3_we_d     = wb_en;
      lat_ws_d    = lat_ws_q;
      lat_we_d    = lat_we_q;
      if (mul_busy) begin
         if (mul_last) begin
            s3_aluout_d = mul_product;
            s3_ws_d     = lat_ws_q;
            s3_we_d     = lat_we_q;
         end else begin
            s3_aluout_d = s3_aluout_q;
            s3_ws_d     = s3_ws_q;
            s3_we_d     = 1'b0;
         end
      end else if (mul_start) begin
         lat_ws_d    = S2_WriteSelect;
         lat_we_d    = wb_en;
         s3_aluout_d = s3_aluout_q;
         s3_ws_d     = s3_ws_q;
         s3_we_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_ws_q <= '0;
         lat_we_q <= 1'b0;
      end else begin
         lat_ws_q <= lat_ws_d;
         lat_we_q <= lat_we_d;
      end
   end
`else
   assign Stall = 1'b0;

   always_comb begin
      s3_aluout_d = alu_res;
      s3_ws_d     = S2_WriteSelect;
      s3_we_d     = wb_en;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_aluout_q <= '0;
         s3_ws_q     <= '0;
         s3_we_q     <= 1'b0;
      end else begin
         s3_aluout_q <= s3_aluout_d;
         s3_ws_q     <= s3_ws_d;
         s3_we_q     <= s3_we_d;
      end
   end

   assign S3_ALUOut      = s3_aluout_q;
   assign S3_WriteSelect = s3_ws_q;
   assign S3_WriteEnable = s3_we_q;

endmodule

// File: tb/tb_s3_execute_stage.sv
module tb_s3_execute_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] S2_ReadData1;
   logic [31:0] S2_ReadData2;
   logic [15:0] S2_Imm;
   logic        S2_DataSrc;
   logic [2:0]  S2_ALUOP;
   logic [4:0]  S2_WriteSelect;
   logic        S2_WriteEnable;
   logic [31:0] S3_ALUOut;
   logic [4:0]  S3_WriteSelect;
   logic        S3_WriteEnable;
   logic        Stall;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [15:0] imm;
      logic        src;
      logic [2:0]  op;
      logic [4:0]  ws;
      logic        we;
      logic [31:0] exp_out;
      logic [4:0]  exp_ws;
      logic        exp_we;
   } vec_t;

   vec_t        vecs[$];
   logic [37:0] exp_q[$];

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   s3_execute_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .S2_ReadData1   (S2_ReadData1),
      .S2_ReadData2   (S2_ReadData2),
      .S2_Imm         (S2_Imm),
      .S2_DataSrc     (S2_DataSrc),
      .S2_ALUOP       (S2_ALUOP),
      .S2_WriteSelect (S2_WriteSelect),
      .S2_WriteEnable (S2_WriteEnable),
      .S3_ALUOut      (S3_ALUOut),
      .S3_WriteSelect (S3_WriteSelect),
      .S3_WriteEnable (S3_WriteEnable),
      .Stall          (Stall)
   );

   // ---------------- driver / checker tasks ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [15:0] imm,
                        input logic src, input logic [2:0] op, input logic [4:0] ws,
                        input logic we);
      S2_ReadData1   = a;
      S2_ReadData2   = b;
      S2_Imm         = imm;
      S2_DataSrc     = src;
      S2_ALUOP       = op;
      S2_WriteSelect = ws;
      S2_WriteEnable = we;
   endtask

`ifdef S3_MUL_EN
   // Issues a MUL at the next negedge and follows it to write-back (N=32).
   task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] ws,
                          input logic [31:0] exp);
      @(negedge clk);
      drive(a, b, 16'h0, 1'b0, 3'b111, ws, 1'b1);
      for (int k = 0; k < 32; k++) begin
         #1 check("mul_stall_high", {31'b0, Stall}, 32'd1);
         @(posedge clk);
         #1 check("mul_bubble_we", {31'b0, S3_WriteEnable}, 32'd0);
         @(negedge clk);
      end
      #1 check("mul_stall_final", {31'b0, Stall}, 32'd0);
      @(posedge clk);
      #1;
      check("mul_out", S3_ALUOut, exp);
      check("mul_ws", {27'b0, S3_WriteSelect}, {27'b0, ws});
      check("mul_we", {31'b0, S3_WriteEnable}, 32'd1);
   endtask
`endif

   // ---------------- stimulus + scoreboard ----------------
   initial begin
      logic [37:0] exp_word;
      rst_n = 1'b0;
      drive(32'h0, 32'h0, 16'h0, 1'b0, 3'b000, 5'd0, 1'b0);

      vecs.push_back(vec_t'{32'h5, 32'hDEAD, 16'hFFFF, 1'b1, 3'b000, 5'd3, 1'b1, 32'h4, 5'd3, 1'b1});
      vecs.push_back(vec_t'{32'd10, 32'd3, 16'h0, 1'b0, 3'b001, 5'd4, 1'b1, 32'd7, 5'd4, 1'b1});
      vecs.push_back(vec_t'{32'hF0F0F0F0, 32'h0FF00FF0, 16'h0, 1'b0, 3'b010, 5'd5, 1'b1, 32'h00F000F0, 5'd5, 1'b1});
      vecs.push_back(vec_t'{32'h12340000, 32'h00005678, 16'h0, 1'b0, 3'b011, 5'd6, 1'b1, 32'h12345678, 5'd6, 1'b1});
      vecs.push_back(vec_t'{32'hFFFF0000, 32'h0F0F0F0F, 16'h0, 1'b0, 3'b100, 5'd7, 1'b1, 32'hF0F00F0F, 5'd7, 1'b1});
      vecs.push_back(vec_t'{32'h1, 32'h21, 16'h0, 1'b0, 3'b101, 5'd8, 1'b1, 32'h2, 5'd8, 1'b1});
      vecs.push_back(vec_t'{32'h3, 32'h1F, 16'h0, 1'b0, 3'b101, 5'd9, 1'b1, 32'h80000000, 5'd9, 1'b1});
      vecs.push_back(vec_t'{32'hFFFFFFFF, 32'h1, 16'h0, 1'b0, 3'b110, 5'd10, 1'b1, 32'h1, 5'd10, 1'b1});
      vecs.push_back(vec_t'{32'h1, 32'hFFFFFFFF, 16'h0, 1'b0, 3'b110, 5'd11, 1'b1, 32'h0, 5'd11, 1'b1});
      vecs.push_back(vec_t'{32'h1, 32'h1, 16'h0, 1'b0, 3'b000, 5'd0, 1'b1, 32'h2, 5'd0, 1'b0});
      vecs.push_back(vec_t'{32'h8, 32'h1, 16'h0, 1'b0, 3'b000, 5'd12, 1'b0, 32'h9, 5'd12, 1'b0});
      vecs.push_back(vec_t'{32'h0, 32'h1, 16'h0, 1'b0, 3'b001, 5'd31, 1'b1, 32'hFFFFFFFF, 5'd31, 1'b1});
      vecs.push_back(vec_t'{32'h0, 32'h0, 16'h8000, 1'b1, 3'b000, 5'd13, 1'b1, 32'hFFFF8000, 5'd13, 1'b1});
`ifndef S3_MUL_EN
      vecs.push_back(vec_t'{32'h7, 32'h6, 16'h0, 1'b0, 3'b111, 5'd14, 1'b1, 32'h0, 5'd14, 1'b1});
`endif

      // Reset state, before any clock edge.
      #1;
      check("reset_out", S3_ALUOut, 32'h0);
      check("reset_ws", {27'b0, S3_WriteSelect}, 32'h0);
      check("reset_we", {31'b0, S3_WriteEnable}, 32'h0);
      check("reset_stall", {31'b0, Stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Single-cycle table.
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].op, vecs[i].ws, vecs[i].we);
         exp_q.push_back({vecs[i].exp_we, vecs[i].exp_ws, vecs[i].exp_out});
         #1 check("vec_stall", {31'b0, Stall}, 32'd0);
         @(posedge clk);
         #1;
         exp_word = exp_q.pop_front();
         check($sformatf("vec%0d_out", i), S3_ALUOut, exp_word[31:0]);
         check($sformatf("vec%0d_ws", i), {27'b0, S3_WriteSelect}, {27'b0, exp_word[36:32]});
         check($sformatf("vec%0d_we", i), {31'b0, S3_WriteEnable}, {31'b0, exp_word[37]});
      end

      // Asynchronous reset mid-stream, observed before the next edge.
      @(negedge clk);
      drive(32'd1, 32'd2, 16'h0, 1'b0, 3'b000, 5'd6, 1'b1);
      @(posedge clk);
      #1 check("pre_rst_out", S3_ALUOut, 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out", S3_ALUOut, 32'h0);
      check("async_rst_ws", {27'b0, S3_WriteSelect}, 32'h0);
      check("async_rst_we", {31'b0, S3_WriteEnable}, 32'h0);
      check("async_rst_stall", {31'b0, Stall}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

`ifdef S3_MUL_EN
      run_mul(32'd7, 32'd6, 5'd9, 32'd42);
      // Second MUL issued right after the first completes.
      run_mul(32'h00010000, 32'h00010000, 5'd5, 32'h0);
      run_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 32'h1);
      @(negedge clk);
      drive(32'd3, 32'd4, 16'h0, 1'b0, 3'b000, 5'd2, 1'b1);
      #1 check("post_mul_stall", {31'b0, Stall}, 32'd0);
      @(posedge clk);
      #1;
      check("post_mul_add_out", S3_ALUOut, 32'd7);
      check("post_mul_add_we", {31'b0, S3_WriteEnable}, 32'd1);

      // Reset while BUSY with cnt=10.
      @(negedge clk);
      drive(32'd7, 32'd6, 16'h0, 1'b0, 3'b111, 5'd9, 1'b1);
      repeat (11) @(posedge clk);
      @(negedge clk);
      #1 check("midmul_stall_before", {31'b0, Stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midmul_rst_stall", {31'b0, Stall}, 32'd0);
      check("midmul_rst_we", {31'b0, S3_WriteEnable}, 32'd0);
      check("midmul_rst_out", S3_ALUOut, 32'd0);
      drive(32'h0, 32'h0, 16'h0, 1'b0, 3'b000, 5'd0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         check("midmul_no_wb_we", {31'b0, S3_WriteEnable}, 32'd0);
         check("midmul_no_wb_out", S3_ALUOut, 32'd0);
      end
`else
      // MUL is single-cycle zero; Stall stays low across repeated MULs.
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         drive(32'h1234 + k, 32'h5678, 16'h0, 1'b0, 3'b111, 5'd20, 1'b1);
         #1 check("nomul_stall", {31'b0, Stall}, 32'd0);
         @(posedge clk);
         #1;
         check("nomul_out", S3_ALUOut, 32'd0);
         check("nomul_we", {31'b0, S3_WriteEnable}, 32'd1);
      end
`endif

      // ---------------- final report ----------------
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
